lcd_nibble_strobe: RTL and testbench
====================================

Name: lcd_nibble_strobe

Overview:
- Physical-layer stage of the LCD path, driving the HD44780-style display pins in 4-bit mode.
- Sits directly downstream of the init/text sequencer, which supplies one 5-bit word per transfer: RS in bit 4, data nibble in bits 3:0.
- Each word gets correct RS/data setup, an E strobe with guaranteed width and hold, then a caller-specified post-command execution delay.
- Completion is signalled with a single-cycle pulse.

Parameters:
- FREQ, 50000000, system clock frequency in Hz (documentation and derived constants only).
- SETUP_CYC, 2, cycles LCD_D is stable before LCD_E rises (≥40 ns at 50 MHz); must be ≥1.
- PULSE_CYC, 12, cycles LCD_E is held high (≥230 ns); must be ≥1.
- HOLD_CYC, 1, cycles LCD_D is held after LCD_E falls (≥10 ns); must be ≥1.
- DELAY_W, 21, width of commandDelay and of the internal cycle counter.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- sendCommand  in  1  level request; held high by the upstream block until it sees commandDone.
- command  in  5  bit 4 = RS, bits 3:0 = nibble; sampled only on accept.
- commandDelay  in  DELAY_W  post-strobe wait in CLK cycles; sampled only on accept.
- commandDone  out  1  one-cycle completion pulse (registered).
- busy  out  1  high in every state except IDLE.
- LCD_D  out  5  {RS, D7..D4} to the panel (registered).
- LCD_E  out  1  enable strobe (registered).

Behaviour:
- Reset: asynchronous and active-high.
  - State goes to IDLE.
  - LCD_E=0, LCD_D=0, commandDone=0, busy=0, counter=0, latched command/delay=0.
  - Reset mid-transfer drops LCD_E immediately; no commandDone is produced for the aborted word.
- State machine and transitions:
  - IDLE: if sendCommand=1, latch command and commandDelay, load counter with SETUP_CYC-1, drive LCD_D=command, go SETUP. The edge at which this happens is the accept edge (cycle 0).
  - SETUP: LCD_E=0, LCD_D stable. When counter=0, load PULSE_CYC-1 and go PULSE; otherwise decrement.
  - PULSE: LCD_E=1. When counter=0, load HOLD_CYC-1 and go HOLD.
  - HOLD: LCD_E=0, LCD_D unchanged. When counter=0: if latched delay=0, go DONE; otherwise load delay-1 and go WAIT.
  - WAIT: LCD_E=0. When counter=0, go DONE.
  - DONE: commandDone=1 for exactly this cycle, then go REARM.
  - REARM: wait until sendCommand=0, then go IDLE. This prevents re-sending the same word while upstream is still reacting to commandDone.
- Timing with an accept at edge 0:
  - LCD_D valid from cycle 1.
  - LCD_E high in cycles SETUP_CYC+1 .. SETUP_CYC+PULSE_CYC.
  - commandDone high in cycle SETUP_CYC+PULSE_CYC+HOLD_CYC+commandDelay+1.
- LCD_D keeps the last word after completion until the next accept or reset.
- Request and input rules:
  - sendCommand, command and commandDelay changes outside IDLE are ignored.
  - A request that drops while the block is busy does not abort the transfer.
- Boundary values:
  - commandDelay=0 skips WAIT entirely.
  - commandDelay = 2^DELAY_W-1 is counted fully with no wrap.
- Upstream contract: sendCommand goes low in the cycle after commandDone and may return high the cycle after that. REARM→IDLE must allow this back-to-back turnaround with no lost word.

Decomposition:
- Shared package lcd_pkg:
  - FREQ and derived cycle constants T1US, T10US, T53US, T100US, T3MS, T4_1MS.
  - RS bit index (4) and the RS=1 mask 5'b10000.
  - State enum {IDLE, SETUP, PULSE, HOLD, WAIT, DONE, REARM}.
- Optional sub-module: lcd_cycle_timer, a DELAY_W-bit loadable down-counter with a zero flag. The block is otherwise a single module.

Test Plan:
- Defaults; command=5'b10100, delay=5, sendCommand held until done:
  - LCD_D=10100 from cycle 1.
  - LCD_E=1 in cycles 3..14 only.
  - commandDone=1 in cycle 21 only.
  - busy=0 after REARM sees sendCommand=0.
- delay=0, command=5'b00011 → commandDone in cycle 16; no WAIT cycles.
- Back-to-back: upstream drops the request one cycle after done and re-raises the next cycle with 5'b01100 → second accept occurs; exactly two done pulses; LCD_D=01100 during the second strobe.
- sendCommand held high continuously after done → block stays in REARM; no second strobe; commandDone stays 0.
- RST asserted in cycle 8 (mid-PULSE) → LCD_E, LCD_D and busy go to 0 asynchronously with no done pulse; after release, a new request completes normally.
- Change command/commandDelay during SETUP and WAIT → no effect on LCD_D or on the done cycle (latched values used).

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD path.
// Holds the clock frequency, derived delay constants used by the
// upstream init/text sequencer, the RS field of the 5-bit command word,
// and the state encoding of the nibble strobe stage.
package lcd_pkg;

  localparam int unsigned FREQ = 50_000_000;

  // Cycle counts for the standard HD44780 execution delays.
  localparam int unsigned T1US   = FREQ / 1_000_000;
  localparam int unsigned T10US  = FREQ / 100_000;
  localparam int unsigned T53US  = (FREQ / 1_000_000) * 53;
  localparam int unsigned T100US = FREQ / 10_000;
  localparam int unsigned T3MS   = (FREQ / 1_000) * 3;
  localparam int unsigned T4_1MS = (FREQ / 10_000) * 41;

  // Command word layout: {RS, D7..D4}.
  localparam int unsigned RS_BIT  = 4;
  localparam logic [4:0]  RS_MASK = 5'b10000;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT,
    DONE,
    REARM
  } lcd_state_t;

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter with a zero flag.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : load value on the next rising edge (takes priority)
//   value    : count to load
//   zero     : high while the count is zero
// The count decrements by one per cycle and parks at zero.
module lcd_cycle_timer #(
  parameter int unsigned WIDTH = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_nibble_strobe.sv
// Physical-layer stage driving an HD44780-style panel in 4-bit mode.
// Accepts one 5-bit word ({RS, nibble}) per request, presents it on
// LCD_D, strobes LCD_E with fixed setup/pulse/hold timing, waits the
// caller-supplied execution delay and pulses commandDone for one cycle.
// Ports:
//   CLK, RST     : clock, asynchronous active-high reset
//   sendCommand  : level request, held until commandDone is seen
//   command      : {RS, D7..D4}, latched on accept
//   commandDelay : post-strobe wait in cycles, latched on accept
//   commandDone  : one-cycle completion pulse (registered)
//   busy         : high in every state except IDLE
//   LCD_D, LCD_E : panel data and enable (registered)
module lcd_nibble_strobe #(
  parameter int unsigned FREQ      = 50_000_000,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 12,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned DELAY_W   = 21
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               sendCommand,
  input  logic [4:0]         command,
  input  logic [DELAY_W-1:0] commandDelay,
  output logic               commandDone,
  output logic               busy,
  output logic [4:0]         LCD_D,
  output logic               LCD_E
);

  import lcd_pkg::*;

  if (FREQ == 0 || SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_params
    $error("lcd_nibble_strobe: FREQ and all strobe cycle counts must be nonzero");
  end

  lcd_state_t         state;
  lcd_state_t         state_next;
  logic [DELAY_W-1:0] delay_q;
  logic               accept;
  logic               load;
  logic [DELAY_W-1:0] load_value;
  logic               zero;

  lcd_cycle_timer #(
    .WIDTH(DELAY_W)
  ) u_timer (
    .clk  (CLK),
    .rst  (RST),
    .load (load),
    .value(load_value),
    .zero (zero)
  );

  // Each phase loads the timer with (length - 1) on entry, so the
  // phase lasts exactly 'length' cycles before zero is seen.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    load       = 1'b0;
    load_value = '0;
    case (state)
      IDLE: begin
        if (sendCommand) begin
          accept     = 1'b1;
          load       = 1'b1;
          load_value = DELAY_W'(SETUP_CYC - 1);
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (zero) begin
          load       = 1'b1;
          load_value = DELAY_W'(PULSE_CYC - 1);
          state_next = PULSE;
        end
      end
      PULSE: begin
        if (zero) begin
          load       = 1'b1;
          load_value = DELAY_W'(HOLD_CYC - 1);
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (zero) begin
          if (delay_q == '0) begin
            state_next = DONE;
          end else begin
            load       = 1'b1;
            load_value = delay_q - DELAY_W'(1);
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (zero) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = REARM;
      end
      REARM: begin
        // Hold off until upstream has dropped its request, so the
        // word just completed is not taken a second time.
        if (!sendCommand) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // LCD_E and commandDone are registered from the next state so they
  // line up exactly with the PULSE and DONE cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      delay_q     <= '0;
      LCD_D       <= '0;
      LCD_E       <= 1'b0;
      commandDone <= 1'b0;
    end else begin
      state       <= state_next;
      LCD_E       <= (state_next == PULSE);
      commandDone <= (state_next == DONE);
      if (accept) begin
        LCD_D   <= command;
        delay_q <= commandDelay;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_lcd_nibble_strobe.sv
module tb_lcd_nibble_strobe;

  localparam int unsigned S  = 2;
  localparam int unsigned P  = 12;
  localparam int unsigned H  = 1;
  localparam int unsigned DW = 21;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          sendCommand = 1'b0;
  logic [4:0]    command = '0;
  logic [DW-1:0] commandDelay = '0;
  logic          commandDone;
  logic          busy;
  logic [4:0]    LCD_D;
  logic          LCD_E;

  // Narrow-counter instance used to exercise the all-ones delay.
  logic          m_send = 1'b0;
  logic [4:0]    m_cmd = '0;
  logic [7:0]    m_delay = '0;
  logic          m_done;
  logic          m_busy;
  logic [4:0]    m_d;
  logic          m_e;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  lcd_nibble_strobe dut (
    .CLK         (CLK),
    .RST         (RST),
    .sendCommand (sendCommand),
    .command     (command),
    .commandDelay(commandDelay),
    .commandDone (commandDone),
    .busy        (busy),
    .LCD_D       (LCD_D),
    .LCD_E       (LCD_E)
  );

  lcd_nibble_strobe #(
    .DELAY_W(8)
  ) dut_max (
    .CLK         (CLK),
    .RST         (RST),
    .sendCommand (m_send),
    .command     (m_cmd),
    .commandDelay(m_delay),
    .commandDone (m_done),
    .busy        (m_busy),
    .LCD_D       (m_d),
    .LCD_E       (m_e)
  );

  typedef struct {
    logic [4:0]  cmd;
    int unsigned dly;
    int unsigned exp_done;
    bit          hold_high;
    bit          scramble;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: word accepted at edge 0 finishes after setup, pulse,
  // hold and the requested delay, with the done pulse one cycle later.
  function automatic int unsigned model_done(input int unsigned dly);
    return S + P + H + dly + 1;
  endfunction

  task automatic run_word(input logic [4:0] cmd, input int unsigned dly,
                          input int unsigned exp_done, input bit hold_high,
                          input bit scramble);
    int unsigned e_first, e_last, e_cnt, d_cyc, d_bad;
    int unsigned extra_e, extra_done, extra_idle, extra_d;
    e_first = 0; e_last = 0; e_cnt = 0; d_cyc = 0; d_bad = 0;
    @(negedge CLK);
    check("idle_before_accept", busy, 0);
    sendCommand  = 1'b1;
    command      = cmd;
    commandDelay = DW'(dly);
    for (int unsigned i = 1; i <= exp_done + 10 && d_cyc == 0; i++) begin
      @(negedge CLK);
      if (scramble) begin
        command      = 5'($urandom);
        commandDelay = DW'($urandom_range(0, 400));
      end
      if (LCD_E) begin
        if (e_cnt == 0) e_first = i;
        e_last = i;
        e_cnt++;
      end
      if (LCD_D != cmd) d_bad++;
      if (commandDone) d_cyc = i;
    end
    check("done_cycle", d_cyc, exp_done);
    check("e_first_cycle", e_first, S + 1);
    check("e_last_cycle", e_last, S + P);
    check("e_high_count", e_cnt, P);
    check("lcd_d_stable", d_bad, 0);
    if (hold_high) begin
      extra_e = 0; extra_done = 0; extra_idle = 0; extra_d = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge CLK);
        if (LCD_E) extra_e++;
        if (commandDone) extra_done++;
        if (!busy) extra_idle++;
        if (LCD_D != cmd) extra_d++;
      end
      check("rearm_held_no_strobe", extra_e, 0);
      check("rearm_held_no_done", extra_done, 0);
      check("rearm_held_busy", extra_idle, 0);
      check("rearm_held_lcd_d", extra_d, 0);
      sendCommand = 1'b0;
    end else begin
      @(negedge CLK);
      check("done_single_cycle", commandDone, 0);
      check("rearm_busy", busy, 1);
      check("lcd_d_kept", LCD_D, cmd);
      sendCommand = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cnt_e, cnt_done, m_cyc, m_ecnt;

    vecs[0] = '{cmd: 5'b10100, dly: 5,   exp_done: 21,  hold_high: 1'b0, scramble: 1'b0};
    vecs[1] = '{cmd: 5'b00011, dly: 0,   exp_done: 16,  hold_high: 1'b0, scramble: 1'b1};
    vecs[2] = '{cmd: 5'b01100, dly: 0,   exp_done: 16,  hold_high: 1'b0, scramble: 1'b0};
    vecs[3] = '{cmd: 5'b11111, dly: 1,   exp_done: 17,  hold_high: 1'b1, scramble: 1'b0};
    vecs[4] = '{cmd: 5'b00000, dly: 300, exp_done: 316, hold_high: 1'b0, scramble: 1'b1};

    repeat (3) @(negedge CLK);
    check("reset_lcd_e", LCD_E, 0);
    check("reset_lcd_d", LCD_D, 0);
    check("reset_done", commandDone, 0);
    check("reset_busy", busy, 0);
    RST = 1'b0;

    // Directed vectors, issued back-to-back with the minimum turnaround.
    foreach (vecs[v])
      run_word(vecs[v].cmd, vecs[v].dly, vecs[v].exp_done, vecs[v].hold_high, vecs[v].scramble);

    // Reset in the middle of the enable pulse.
    @(negedge CLK);
    sendCommand  = 1'b1;
    command      = 5'b10110;
    commandDelay = DW'(5);
    repeat (8) @(negedge CLK);
    check("e_high_before_reset", LCD_E, 1);
    RST = 1'b1;
    sendCommand = 1'b0;
    #1;
    check("async_reset_lcd_e", LCD_E, 0);
    check("async_reset_lcd_d", LCD_D, 0);
    check("async_reset_busy", busy, 0);
    @(negedge CLK);
    RST = 1'b0;
    cnt_e = 0; cnt_done = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge CLK);
      if (LCD_E) cnt_e++;
      if (commandDone) cnt_done++;
    end
    check("aborted_no_strobe", cnt_e, 0);
    check("aborted_no_done", cnt_done, 0);
    run_word(5'b01001, 3, 19, 1'b0, 1'b0);

    // Randomized words against the timing model.
    for (int n = 0; n < 20; n++) begin
      int unsigned d;
      d = $urandom_range(0, 300);
      run_word(5'($urandom), d, model_done(d), 1'b0, 1'b1);
    end
    @(negedge CLK);
    check("final_idle", busy, 0);

    // All-ones delay on an 8-bit counter: counted in full, no wrap.
    @(negedge CLK);
    m_send = 1'b1; m_cmd = 5'b10001; m_delay = 8'hFF;
    m_cyc = 0; m_ecnt = 0;
    for (int unsigned i = 1; i <= 300 && m_cyc == 0; i++) begin
      @(negedge CLK);
      if (m_e) m_ecnt++;
      if (m_done) m_cyc = i;
    end
    check("max_delay_done_cycle", m_cyc, S + P + H + 255 + 1);
    check("max_delay_e_count", m_ecnt, P);
    check("max_delay_lcd_d", m_d, 5'b10001);
    @(negedge CLK);
    m_send = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("max_delay_idle", m_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
